// File: rtl/proj_qsys_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, per-key debounce window,
// active-high clean level and one-cycle press/release pulses.
//
// state   | meaning
// STABLE  | synchronised level matches key_clean, counter held at 0
// PENDING | synchronised level differs from key_clean, counting the hold window
module proj_qsys_button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_clean,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;
    logic [WIDTH-1:0] lvl;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    state_t           state   [WIDTH];
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] press_nxt;
    logic [WIDTH-1:0] release_nxt;

    assign lvl = (ACTIVE_LOW != 0) ? ~sync_2 : sync_2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1      <= IDLE_RAW;
            sync_2      <= IDLE_RAW;
            key_clean   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_1      <= key_raw;
            sync_2      <= sync_1;
            key_clean   <= clean_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // The state is implied by the level mismatch; no extra register is kept.
    always_comb begin
        clean_nxt   = key_clean;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            state[i]   = (lvl[i] != key_clean[i]) ? PENDING : STABLE;
            case (state[i])
                STABLE: begin
                    cnt_nxt[i] = '0;
                end
                PENDING: begin
                    if (cnt[i] == CNT_LAST) begin
                        cnt_nxt[i]     = '0;
                        clean_nxt[i]   = lvl[i];
                        press_nxt[i]   = lvl[i];
                        release_nxt[i] = ~lvl[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proj_qsys_button_debounce.sv
// Bench for proj_qsys_button_debounce: a window-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_proj_qsys_button_debounce;

    localparam int W = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] key_raw = 4'hF;
    logic [W-1:0] key_clean;
    logic [W-1:0] key_press;
    logic [W-1:0] key_release;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int pulses_k2 = 0;

    proj_qsys_button_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_raw(key_raw),
        .key_clean(key_clean),
        .key_press(key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Model: pressed-level seen by the debouncer before edge n is the key
    // sampled two edges earlier (idle right after reset). A key is accepted
    // at edge n when that level has disagreed with key_clean for the last D edges.
    logic [W-1:0] hist [$];
    int           n_edge;
    logic [W-1:0] m_clean, m_press, m_rel;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            n_edge  = 0;
            m_clean = '0;
            m_press = '0;
            m_rel   = '0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            if (n_edge >= D - 1) begin
                for (int b = 0; b < W; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (hist[n_edge - j][b] == m_clean[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_clean[b] = ~m_clean[b];
                        m_press[b] = m_clean[b];
                        m_rel[b]   = ~m_clean[b];
                    end
                end
            end
            hist.push_back(~key_raw);
            n_edge++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ({key_clean, key_press, key_release} !== {m_clean, m_press, m_rel}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t clean/press/rel got %b/%b/%b want %b/%b/%b",
                         $time, key_clean, key_press, key_release, m_clean, m_press, m_rel);
            end
            n_tests++;
            if ((key_press & key_release) != '0) begin
                n_fail++;
                $display("FAIL press_and_release t=%0t press %b release %b", $time, key_press, key_release);
            end
            if (key_press[2] || key_release[2]) pulses_k2++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    initial begin
        int p0;
        // 1: reset with keys idle, then hold
        key_raw = 4'hF;
        reset_n = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        chk("rst_clean", key_clean, 4'h0);
        chk("rst_press", key_press, 4'h0);
        reset_n = 1'b1;
        cyc(20);
        chk("idle_clean", key_clean, 4'h0);
        chk("idle_rel", key_release, 4'h0);

        // 2: key 0 pressed; next posedge is edge 0, accept at edge 9
        key_raw = 4'b1110;
        cyc(9);
        chk("k0_before", key_clean, 4'b0000);
        cyc(1);
        chk("k0_clean", key_clean, 4'b0001);
        chk("k0_press", key_press, 4'b0001);
        cyc(1);
        chk("k0_press_once", key_press, 4'b0000);

        // 3: key 1 glitch 5 low / 2 high, then held low
        key_raw = 4'b1100;
        cyc(5);
        key_raw = 4'b1110;
        cyc(2);
        key_raw = 4'b1100;
        cyc(9);
        chk("k1_before", key_clean, 4'b0001);
        cyc(1);
        chk("k1_clean", key_clean, 4'b0011);
        chk("k1_press", key_press, 4'b0010);

        // 4: keys 2,3 together, released together 30 cycles later
        key_raw = 4'b0000;
        cyc(10);
        chk("k23_press", key_press, 4'b1100);
        chk("k23_clean", key_clean, 4'b1111);
        cyc(20);
        key_raw = 4'b1100;
        cyc(10);
        chk("k23_release", key_release, 4'b1100);
        chk("k23_clean_off", key_clean, 4'b0011);
        key_raw = 4'hF;
        cyc(12);
        chk("all_released", key_clean, 4'b0000);

        // 5: reset in the middle of key 0's window, key kept pressed
        key_raw = 4'b1110;
        cyc(4);
        reset_n = 1'b0;
        cyc(1);
        chk("midrst_clean", key_clean, 4'h0);
        chk("midrst_press", key_press, 4'h0);
        cyc(1);
        reset_n = 1'b1;
        // first posedge after release samples the key (edge 0); accept at edge 9
        cyc(9);
        chk("postrst_before", key_clean, 4'b0000);
        cyc(1);
        chk("postrst_clean", key_clean, 4'b0001);
        chk("postrst_press", key_press, 4'b0001);

        // 6: bounce train on key 2, then settles released
        p0 = pulses_k2;
        for (int k = 0; k < 34; k++) begin
            key_raw[2] = (k % 2 == 1);
            cyc(3);
        end
        key_raw[2] = 1'b1;
        cyc(20);
        chk("bounce_clean", key_clean, 4'b0001);
        n_tests++;
        if (pulses_k2 != p0) begin
            n_fail++;
            $display("FAIL bounce_pulses got %0d want 0", pulses_k2 - p0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
